mul_unit: RTL and testbench
===========================

// Module: mul_unit
// PURPOSE
//   Unsigned integer multiplier with a registered result, used as the
//   multiply stage of the factorial datapath.
//   Takes two SIZE_-bit operands and returns the low SIZE_ bits of their
//   product one clock later. The block also flags when the true product
//   does not fit in SIZE_ bits.
//   Free-running: no handshake. A new product is produced every cycle.
// PARAMETERS
//   SIZE_  8  operand and result width in bits (legal range 2..32)
// PORTS
//   clk_  input   1       clock, rising-edge active
//   rst_  input   1       asynchronous reset, active-high
//   x_    input   SIZE_   multiplicand, unsigned
//   y_    input   SIZE_   multiplier, unsigned
//   z_    output  SIZE_   registered product, low SIZE_ bits, unsigned
//   ovf_  output  1       registered overflow flag: full product >= 2**SIZE_
// BEHAVIOUR
// - Interface: one clock (clk_); reset rst_ is asynchronous, active-high.
// - Reset:
//   - While rst_=1: z_=0 and ovf_=0 immediately, independent of clk_.
//   - The first capture occurs on the first rising clk_ edge after rst_
//     deasserts.
// - Datapath, combinational part:
//   - Unsigned shift-add array multiply.
//   - Partial product i = y_[i] ? (x_ << i) : 0, for i = 0..SIZE_-1.
//   - The partial products are summed into a 2*SIZE_-bit full product P.
// - Register, on each rising clk_ edge with rst_=0:
//   - z_ <= P[SIZE_-1:0], i.e. the product truncated modulo 2**SIZE_.
//   - ovf_ <= |P[2*SIZE_-1:SIZE_].
// - Latency:
//   - Exactly 1 cycle; z_ and ovf_ always correspond to the operands
//     sampled at the most recent rising edge.
//   - Outputs are stable between edges.
//   - Throughput is one product per cycle.
// - No internal state beyond the output registers; no enable and no valid
//   signal.
// - Operands changing between edges have no effect until the next edge.
//   Operands are sampled only at the edge.
// - Boundaries:
//   - x_=0 or y_=0 -> z_=0, ovf_=0.
//   - x_=1 -> z_=y_, ovf_=0.
//   - Maximum operands wrap: (2**SIZE_-1)**2 mod 2**SIZE_ = 1, ovf_=1.
//   - Exact power-of-two overflow, e.g. 16*16 at SIZE_=8:
//     z_=0, ovf_=1.
// - Reset asserted mid-operation clears both outputs immediately.
//   The product captured at the next edge after release reflects the
//   operands at that edge only.
// - No X propagation from reset: all output flops must be reset.
// TESTING
// - Reset:
//   - assert rst_=1 with x_=7, y_=9 and toggle clk_ -> z_=0, ovf_=0
//     throughout.
//   - deassert rst_ -> z_=63 after the next rising edge.
// - Sweep, SIZE_=8:
//   - x_,y_ in 0..9, changing once per 10-unit clock period, just after
//     the rising edge.
//   - at the next sampling point, z_ == x_*y_ for all 100 pairs
//     (e.g. 9*9 -> 81), ovf_=0.
// - Overflow:
//   - x_=255, y_=255 -> z_=1, ovf_=1.
//   - x_=16, y_=16 -> z_=0, ovf_=1.
//   - x_=15, y_=17 -> z_=255, ovf_=0.
// - Latency: change x_ from 3 to 5 with y_=4 between edges -> z_ holds 12
//   until the next rising edge, then reads 20.
// - Async reset mid-stream: pulse rst_ between edges while z_=81 -> z_
//   drops to 0 without a clock edge, then resumes correct products.
// - Parameter: rebuild with SIZE_=4 and sweep all 256 pairs ->
//   z_ == (x_*y_)%16 and ovf_ == (x_*y_ > 15).

Source files
------------

// File: rtl/mul_unit.sv
// -----------------------------------------------------------------------------
// mul_unit
//   Unsigned integer multiplier with a registered result. This is the multiply
//   stage of the factorial datapath.
//
//   The multiplier is a shift-add array. Each bit of y_ selects a copy of x_
//   shifted left by that bit's position. The partial products are summed into
//   a full 2*SIZE_-bit product. On every rising clk_ edge the low SIZE_ bits of
//   that product are registered onto z_. ovf_ records whether any of the high
//   SIZE_ bits were set. The block is free-running and produces one product per
//   cycle with one cycle of latency. It has no handshake, no enable and no
//   internal state beyond the two output registers.
//
// Parameters
//   SIZE_  operand and result width in bits (legal range 2..32)
//
// Ports
//   clk_  in   1      clock, rising-edge active
//   rst_  in   1      asynchronous reset, active-high; clears z_ and ovf_
//   x_    in   SIZE_  multiplicand, unsigned
//   y_    in   SIZE_  multiplier, unsigned
//   z_    out  SIZE_  registered product modulo 2**SIZE_
//   ovf_  out  1      registered flag, set when the full product >= 2**SIZE_
// -----------------------------------------------------------------------------
module mul_unit #(
    parameter int SIZE_ = 8
) (
    input  logic             clk_,
    input  logic             rst_,
    input  logic [SIZE_-1:0] x_,
    input  logic [SIZE_-1:0] y_,
    output logic [SIZE_-1:0] z_,
    output logic             ovf_
);

    localparam int PW = 2 * SIZE_;

    // Returns the partial product selected by one multiplier bit. It is the
    // multiplicand zero-extended to full width and shifted into place, or zero
    // when the bit is clear.
    function automatic logic [PW-1:0] partial_product(
        input logic [SIZE_-1:0] mcand,
        input logic             mbit,
        input int               shift
    );
        logic [PW-1:0] ext;
        ext = {{SIZE_{1'b0}}, mcand};
        if (mbit) begin
            return ext << shift;
        end else begin
            return {PW{1'b0}};
        end
    endfunction

    logic [PW-1:0]    pp_s [SIZE_];
    logic [PW-1:0]    prod_s;
    logic [SIZE_-1:0] prod_lo_s;
    logic             ovf_s;
    logic [SIZE_-1:0] z_r;
    logic             ovf_r;

    // Partial-product array: one row for each multiplier bit.
    always_comb begin
        for (int i = 0; i < SIZE_; i++) begin
            pp_s[i] = partial_product(x_, y_[i], i);
        end
    end

    // Sum the rows into the full-width product. The accumulator is PW bits,
    // which is wide enough that the sum can never wrap.
    always_comb begin
        prod_s = {PW{1'b0}};
        for (int i = 0; i < SIZE_; i++) begin
            prod_s = prod_s + pp_s[i];
        end
    end

    // Split the product into the truncated result and the overflow indication.
    always_comb begin
        prod_lo_s = prod_s[SIZE_-1:0];
        ovf_s     = |prod_s[PW-1:SIZE_];
    end

    // Output registers. Reset clears them immediately, without waiting for a
    // clock edge. Otherwise they capture a new product on every rising edge.
    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            z_r   <= {SIZE_{1'b0}};
            ovf_r <= 1'b0;
        end else begin
            z_r   <= prod_lo_s;
            ovf_r <= ovf_s;
        end
    end

    assign z_   = z_r;
    assign ovf_ = ovf_r;

endmodule

// File: tb/tb_mul_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_unit
//   Directed testbench for mul_unit. It instantiates an 8-bit and a 4-bit
//   multiplier that share a clock and a reset. Every check compares against
//   a hand-computed value or against arithmetic done inside the bench.
// -----------------------------------------------------------------------------
module tb_mul_unit;

    logic       clk;
    logic       rst;
    logic [7:0] x8, y8, z8;
    logic       ovf8;
    logic [3:0] x4, y4, z4;
    logic       ovf4;

    int passed = 0;
    int total  = 0;

    mul_unit #(.SIZE_(8)) dut8 (
        .clk_ (clk),
        .rst_ (rst),
        .x_   (x8),
        .y_   (y8),
        .z_   (z8),
        .ovf_ (ovf8)
    );

    mul_unit #(.SIZE_(4)) dut4 (
        .clk_ (clk),
        .rst_ (rst),
        .x_   (x4),
        .y_   (y4),
        .z_   (z4),
        .ovf_ (ovf4)
    );

    // 10-unit clock with rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Called at posedge+1. Drives the operands, waits for the next capture,
    // then checks both outputs.
    task automatic step8(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ez, input logic eo, input string tag);
        x8 = a;
        y8 = b;
        @(posedge clk);
        #1;
        chk({tag, ".z"}, {24'd0, z8}, {24'd0, ez});
        chk({tag, ".ovf"}, {31'd0, ovf8}, {31'd0, eo});
    endtask

    initial begin
        rst = 1'b1;
        x8  = 8'd7;
        y8  = 8'd9;
        x4  = 4'd3;
        y4  = 4'd2;

        // Hold reset across several edges. The outputs must stay cleared.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst.z8", {24'd0, z8}, 32'd0);
            chk("rst.ovf8", {31'd0, ovf8}, 32'd0);
            chk("rst.z4", {28'd0, z4}, 32'd0);
        end

        // Release reset between edges. The first capture yields 7*9.
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel.z8", {24'd0, z8}, 32'd63);
        chk("rel.ovf8", {31'd0, ovf8}, 32'd0);
        chk("rel.z4", {28'd0, z4}, 32'd6);

        // Small-operand sweep at one product per cycle.
        for (int a = 0; a < 10; a++) begin
            for (int b = 0; b < 10; b++) begin
                step8(8'(a), 8'(b), 8'(a * b), 1'b0, $sformatf("sweep %0d*%0d", a, b));
            end
        end

        // Boundaries and overflow cases.
        step8(8'd255, 8'd255, 8'd1,   1'b1, "max*max");
        step8(8'd16,  8'd16,  8'd0,   1'b1, "16*16");
        step8(8'd15,  8'd17,  8'd255, 1'b0, "15*17");
        step8(8'd1,   8'd200, 8'd200, 1'b0, "1*200");
        step8(8'd0,   8'd255, 8'd0,   1'b0, "0*255");
        step8(8'd128, 8'd2,   8'd0,   1'b1, "128*2");
        step8(8'd3,   8'd4,   8'd12,  1'b0, "3*4");

        // Latency: an operand change between edges has no effect until the
        // next rising edge.
        #2 x8 = 8'd5;
        #1 chk("lat.hold", {24'd0, z8}, 32'd12);
        @(posedge clk);
        #1;
        chk("lat.new", {24'd0, z8}, 32'd20);

        // Asynchronous reset mid-stream.
        step8(8'd9, 8'd9, 8'd81, 1'b0, "9*9");
        #2 rst = 1'b1;
        #1 chk("arst.z", {24'd0, z8}, 32'd0);
        chk("arst.ovf", {31'd0, ovf8}, 32'd0);
        x8 = 8'd20;
        y8 = 8'd20;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("arst.resume.z", {24'd0, z8}, 32'd144);
        chk("arst.resume.ovf", {31'd0, ovf8}, 32'd1);
        step8(8'd6, 8'd7, 8'd42, 1'b0, "6*7");

        // Exhaustive 4-bit sweep.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                x4 = 4'(a);
                y4 = 4'(b);
                @(posedge clk);
                #1;
                chk($sformatf("w4 %0d*%0d.z", a, b), {28'd0, z4}, 32'((a * b) % 16));
                chk($sformatf("w4 %0d*%0d.ovf", a, b), {31'd0, ovf4}, {31'd0, (a * b) > 15});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
